// File: rtl/parity_serial_rx.sv
// Parity-checked serial frame receiver.
// Start, LSB-first data, parity, stop; line idles high.
module parity_serial_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_W + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic          PODD     = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t            state;
  logic              sync1;
  logic              rx_s;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bidx;
  logic [DATA_W-1:0] shreg;
  logic              acc;
  logic              mism;
  logic [DATA_W:0]   shnext;

  // New bit enters at the MSB so the first bit ends up in bit 0.
  assign shnext = {rx_s, shreg};

  assign busy = (state != IDLE);

  // Two-flop synchronizer; idles high so reset looks like a quiet line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  // Frame FSM: mid-bit sampling, parity accumulation, registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bidx       <= '0;
      shreg      <= '0;
      acc        <= 1'b0;
      mism       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            bidx  <= '0;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              acc   <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            shreg <= shnext[DATA_W:1];
            acc   <= acc ^ rx_s;
            if (bidx == LAST_BIT) begin
              state <= PARITY;
            end else begin
              bidx <= bidx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            mism  <= acc ^ rx_s ^ PODD;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt        <= '0;
            data_out   <= shreg;
            data_valid <= 1'b1;
            parity_err <= mism;
            frame_err  <= ~rx_s;
            state      <= rx_s ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
